// File: rtl/seg_scan_display.sv
// Multiplexed N-digit seven-segment scanner with page select, per-digit
// blanking, decimal points, leading-zero suppression and a per-frame shadow
// copy of the inputs so that a frame is never torn by mid-frame updates.

// Per-digit decoder: hex nibble to active-low {dp,g,f,e,d,c,b,a}.
module seg_scan_lane (
   input  logic       dark,
   input  logic       dp,
   input  logic [3:0] nib,
   output logic [7:0] seg
);

   logic [6:0] glyph;

   // Hex glyph table, active-low gfedcba.
   always_comb begin
      glyph = 7'h7F;
      case (nib)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         4'hF: glyph = 7'h0E;
         default: glyph = 7'h7F;
      endcase
   end

   // A dark digit keeps its anode slot but lights nothing, dp included.
   always_comb begin
      seg = dark ? 8'hFF : {~dp, glyph};
   end

endmodule

module seg_scan_display #(
   parameter int NDIGITS    = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   ch,
   input  logic [4*NDIGITS-1:0]   data0,
   input  logic [4*NDIGITS-1:0]   data1,
   input  logic [NDIGITS-1:0]     dp0,
   input  logic [NDIGITS-1:0]     dp1,
   input  logic [NDIGITS-1:0]     blank,
   input  logic                   lzs,
   output logic [NDIGITS-1:0]     AN,
   output logic [7:0]             SEGMENT,
   output logic [2:0]             digit_idx,
   output logic                   frame_done
);

   localparam int                 CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam bit                 AL      = (ACTIVE_LOW != 0);
   localparam logic [NDIGITS-1:0] AN_OFF  = AL ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};
   localparam logic [7:0]         SEG_OFF = AL ? 8'hFF : 8'h00;

   typedef struct packed {
      logic [NDIGITS-1:0][3:0] data;
      logic [NDIGITS-1:0]      dp;
      logic [NDIGITS-1:0]      blank;
      logic                    lzs;
   } frame_t;

   logic [CW-1:0]            cnt;
   logic [2:0]               idx;
   frame_t                   sh;
   frame_t                   sh_next;
   logic                     tick;
   logic                     wrap;
   logic [NDIGITS-1:0]       supp;
   logic                     all_zero;
   logic [NDIGITS-1:0][7:0]  lane_seg;
   logic [7:0]               seg_sel;
   logic [NDIGITS-1:0]       an_sel;

   // Page-selected snapshot candidate and slot/frame boundary strobes.
   always_comb begin
      sh_next.data  = ch ? data1 : data0;
      sh_next.dp    = ch ? dp1 : dp0;
      sh_next.blank = blank;
      sh_next.lzs   = lzs;
      tick          = (cnt == CW'(SCAN_DIV - 1));
      wrap          = tick && (idx == 3'(NDIGITS - 1));
   end

   // Prescaler, digit index and shadow; disable holds the scan at digit 0
   // and keeps the shadow tracking the inputs so a restart shows fresh data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= '0;
         sh         <= '0;
         frame_done <= 1'b0;
      end else if (!en) begin
         cnt        <= '0;
         idx        <= '0;
         sh         <= sh_next;
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap;
         if (tick) begin
            cnt <= '0;
            idx <= wrap ? 3'd0 : idx + 3'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (wrap) sh <= sh_next;
      end
   end

   // Leading-zero suppression: digit i>0 goes dark when it and every
   // digit above it are zero; digit 0 always shows.
   always_comb begin
      supp     = '0;
      all_zero = 1'b1;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero && (sh.data[i] == 4'h0);
         if (i > 0) supp[i] = sh.lzs && all_zero;
      end
   end

   for (genvar g = 0; g < NDIGITS; g++) begin : g_lane
      seg_scan_lane u_lane (
         .dark (sh.blank[g] | supp[g]),
         .dp   (sh.dp[g]),
         .nib  (sh.data[g]),
         .seg  (lane_seg[g])
      );
   end

   // Pick the lane for the current slot; active-low one-hot anode.
   always_comb begin
      seg_sel = 8'hFF;
      an_sel  = '1;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx == 3'(i)) begin
            seg_sel   = lane_seg[i];
            an_sel[i] = 1'b0;
         end
      end
   end

   // Registered pin drivers, polarity applied at the last stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AN        <= AN_OFF;
         SEGMENT   <= SEG_OFF;
         digit_idx <= 3'd0;
      end else if (!en) begin
         AN        <= AN_OFF;
         SEGMENT   <= SEG_OFF;
         digit_idx <= 3'd0;
      end else begin
         AN        <= AL ? an_sel : ~an_sel;
         SEGMENT   <= AL ? seg_sel : ~seg_sel;
         digit_idx <= idx;
      end
   end

endmodule
